// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit with architectural HI/LO.
//   Supports mult, multu, div and divu (one radix-2 step per clock), plus mthi/mtlo.
//   Optional macro MULDIV_FAST_MULT_EN: mult/multu use a single-cycle multiplier
//   (IDLE -> FIX directly). Division always takes the iterative path.
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            synchronous active-low reset
//   start_i, op_i    start request and opcode (00 mult, 01 multu, 10 div, 11 divu)
//   src1_i, src2_i   rs / rt operands; src1_i is also the mthi/mtlo data
//   wr_hi_i, wr_lo_i mthi / mtlo write strobes (IDLE only)
//   busy_o           operation in flight
//   done_o           one-cycle pulse after HI/LO were written by mult/div
//   hi_o, lo_o       HI / LO registers
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q, done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q;
  logic                 is_div_q, neg_lo_q, neg_hi_q, dz_q;

  logic                 sgn_start;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH+1:0]     div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     res_hi, res_lo;

  // Magnitude of a possibly-signed operand; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? $unsigned(-$signed(v)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_dw(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? $unsigned(-$signed(v)) : v;
  endfunction

  always_comb begin
    sgn_start = ~op_i[0];
    mag1      = mag(src1_i, sgn_start);
    mag2      = mag(src2_i, sgn_start);

    // Multiply step: conditionally add multiplicand to upper half, shift right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Divide step: shift remainder:quotient left, trial-subtract divisor.
    rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = {1'b0, rem_sh} - {2'b00, opb_q};

    acc_d = acc_q;
    if (is_div_q) begin
      if (!div_diff[WIDTH+1]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                    acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Sign correction; a zero divisor forces LO to all ones, and HI naturally
    // reconstructs src1 (|src1| with the dividend's sign restored).
    prod_fix = fix_dw(acc_q, neg_lo_q);
    if (is_div_q) begin
      res_hi = fix_w(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
      res_lo = dz_q ? '1 : fix_w(acc_q[WIDTH-1:0], neg_lo_q);
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Datapath registers: loaded on accepted start, stepped during CALC.
  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE && start_i) begin
      is_div_q <= op_i[1];
      neg_lo_q <= sgn_start & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
      neg_hi_q <= sgn_start & src1_i[WIDTH-1];
      dz_q     <= (src2_i == '0);
      opb_q    <= op_i[1] ? mag2 : mag1;
`ifdef MULDIV_FAST_MULT_EN
      if (op_i[1]) acc_q <= {{WIDTH{1'b0}}, mag1};
      else         acc_q <= {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
`else
      acc_q    <= {{WIDTH{1'b0}}, (op_i[1] ? mag1 : mag2)};
`endif
    end else if (state_q == S_CALC) begin
      acc_q <= acc_d;
    end
  end

  // Control FSM with registered busy/done and the architectural HI/LO.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
            state_q <= op_i[1] ? S_CALC : S_FIX;
`else
            state_q <= S_CALC;
`endif
          end else begin
            if (wr_hi_i) hi_q <= src1_i;
            if (wr_lo_i) lo_q <= src1_i;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit. Stimulus pushes the
// expected HI/LO (from a 64-bit arithmetic reference model) and the expected
// done latency; a negedge monitor pops and compares on every done_o pulse.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_i, start_i, wr_hi_i, wr_lo_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i, src2_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .wr_hi_i(wr_hi_i), .wr_lo_i(wr_lo_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          e0;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  logic [31:0] prev_hi, prev_lo;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {HI, LO}.
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb_, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: return 64'(sa * sb_);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
`ifdef MULDIV_FAST_MULT_EN
    return op[1] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  // Monitor: pop and compare on every done pulse; HI/LO must hold while busy.
  always @(negedge clk) begin
    exp_t e;
    if (rst_i === 1'b1 && done_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 at edge %0d", edge_cnt);
      end else begin
        e = sb.pop_front();
        chk("result_hi", hi_o, e.hi);
        chk("result_lo", lo_o, e.lo);
        chk("done_latency", 32'(edge_cnt - e.e0), 32'(e.lat));
      end
    end
    if (rst_i === 1'b1 && busy_o === 1'b1) begin
      chk("hold_hi_busy", hi_o, prev_hi);
      chk("hold_lo_busy", lo_o, prev_lo);
    end
    prev_hi = hi_o;
    prev_lo = lo_o;
  end

  // All tasks below expect to be entered #1 after a rising edge.
  task automatic wait_idle();
    int guard = 0;
    while (busy_o === 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=busy expected=idle");
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic whi);
    exp_t        e;
    logic [63:0] r;
    r     = ref_op(op, a, b);
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.e0  = edge_cnt + 1;
    e.lat = exp_lat(op);
    sb.push_back(e);
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b; wr_hi_i = whi;
    @(posedge clk); #1;
    start_i = 1'b0; wr_hi_i = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; start_i = 1'b0; wr_hi_i = 1'b0; wr_lo_i = 1'b0;
    op_i = 2'b00; src1_i = '0; src2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_hi", hi_o, 32'd0);
    chk("reset_lo", lo_o, 32'd0);
    rst_i = 1'b1;
    @(posedge clk); #1;

    // Boundary products/quotients and back-to-back issue in the done cycle.
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_idle();
    issue(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0);
    wait_idle();
    chk("b2b_issue_in_done_cycle", 32'(done_o), 32'd1);
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle();
    issue(2'b11, 32'd7, 32'd0, 1'b0);
    wait_idle();
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle();
    issue(2'b10, 32'hFFFFFF85, 32'd0, 1'b0);
    wait_idle();

    // mthi / mtlo, then both together.
    wr_hi_i = 1'b1; src1_i = 32'hCAFE0001;
    @(posedge clk); #1;
    wr_hi_i = 1'b0;
    chk("mthi_hi", hi_o, 32'hCAFE0001);
    wr_hi_i = 1'b1; wr_lo_i = 1'b1; src1_i = 32'h0BADBEEF;
    @(posedge clk); #1;
    wr_hi_i = 1'b0; wr_lo_i = 1'b0;
    chk("mthi_mtlo_hi", hi_o, 32'h0BADBEEF);
    chk("mthi_mtlo_lo", lo_o, 32'h0BADBEEF);
    chk("mtx_no_done", 32'(done_o), 32'd0);

    // start with mthi in the same cycle: start wins.
    issue(2'b11, 32'd50, 32'd3, 1'b1);
    wait_idle();

    // Second start and mthi while busy are ignored.
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start_i = 1'b1; op_i = 2'b00; src1_i = 32'hDEAD0000; src2_i = 32'd5; wr_hi_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; wr_hi_i = 1'b0;
    wait_idle();
    @(posedge clk); #1;

    // Reset in the middle of a mult aborts it without touching HI/LO beyond reset.
    start_i = 1'b1; op_i = 2'b00; src1_i = 32'hFFFFFB2E; src2_i = 32'd777;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    chk("midreset_busy", 32'(busy_o), 32'd0);
    chk("midreset_done", 32'(done_o), 32'd0);
    chk("midreset_hi", hi_o, 32'd0);
    chk("midreset_lo", lo_o, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    wr_lo_i = 1'b1; src1_i = 32'h00001234;
    @(posedge clk); #1;
    wr_lo_i = 1'b0;
    chk("mtlo_lo", lo_o, 32'h00001234);
    chk("mtlo_hi", hi_o, 32'd0);
    chk("mtlo_no_done", 32'(done_o), 32'd0);

    // Randomized operations, issued as soon as the unit is free.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      wait_idle();
      issue(op, a, b, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
